// File: rtl/uart_pkg.sv
// Shared UART link constants: system clock, baud rate and the derived
// divide ratio used by the baud-rate tick generators.
`timescale 1ns/1ps
package uart_pkg;

  localparam int unsigned SYS_CLK_HZ = 25_000_000;
  localparam int unsigned BAUD       = 9600;
  localparam int unsigned OVERSAMPLE = 16;

  // Rounded to nearest: 25e6 / 153600 = 162.76, so the divider runs at 163.
  localparam int unsigned BAUD_DIV   = (SYS_CLK_HZ + (BAUD * OVERSAMPLE) / 2)
                                       / (BAUD * OVERSAMPLE);

  localparam int unsigned DIV_CNT_W  = 16;

endpackage

// File: rtl/test_d_clk_divider.sv
// Baud-rate tick generator: counts DIVISOR system clocks per tick. Exposes the
// combinational wrap (last count of a period) alongside the registered tick.
`timescale 1ns/1ps
module clk_divider
  import uart_pkg::*;
#(
  parameter int unsigned DIVISOR = BAUD_DIV,
  parameter int unsigned CNT_W   = DIV_CNT_W
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic wrap
);

  if ((DIVISOR == 0) || ((64'(DIVISOR) - 64'd1) >= (64'd1 << CNT_W))) begin : g_bad_divisor
    $error("clk_divider: DIVISOR must be 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] div_cnt;

  // With DIVISOR=1 LAST is zero, so wrap is always high and div_cnt parks at 0.
  assign wrap = (div_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= wrap;
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/test_d.sv
// Divider self-test: counts baud ticks in a wrapping 8-bit counter so the
// divide rate can be confirmed on LEDs/probes.
`timescale 1ns/1ps
module test_d
  import uart_pkg::*;
#(
  parameter int unsigned DIVISOR = BAUD_DIV,
  parameter int unsigned CNT_W   = DIV_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] result
);

  logic tick;
  logic wrap;

  // tick is the registered strobe the UART blocks consume; the counter uses
  // wrap so its first increment lands on edge DIVISOR rather than DIVISOR+1.
  clk_divider #(
    .DIVISOR (DIVISOR),
    .CNT_W   (CNT_W)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= 8'h00;
    end else if (wrap) begin
      result <= result + 8'h01;
    end
  end

endmodule

// File: tb/tb_test_d.sv
// Randomised reset stimulus on three divider configurations (4, 1, 163), with
// a count-based reference model feeding per-instance expected queues.
`timescale 1ns/1ps
module tb_test_d;

  localparam int NUM_EDGES = 3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst4, rst1, rst163;
  logic [7:0] res4, res1, res163;

  test_d #(.DIVISOR(4),   .CNT_W(16)) dut4   (.clk(clk), .rst(rst4),   .result(res4));
  test_d #(.DIVISOR(1),   .CNT_W(16)) dut1   (.clk(clk), .rst(rst1),   .result(res1));
  test_d #(.DIVISOR(163), .CNT_W(16)) dut163 (.clk(clk), .rst(rst163), .result(res163));

  // ---------------- scoreboard ----------------
  // Each entry is {div_cnt[15:0], tick, result[7:0]} expected after one edge.
  logic [24:0] exp_q4[$];
  logic [24:0] exp_q1[$];
  logic [24:0] exp_q163[$];

  int checks = 0;
  int errors = 0;

  // n = non-reset edges since the last reset edge; all outputs follow from n.
  task automatic model_step(input bit r, input int d, inout int n, output logic [24:0] e);
    if (r) n = 0;
    else   n = n + 1;
    e = {16'(n % d), 1'(!r && (n % d == 0)), 8'((n / d) % 256)};
  endtask

  task automatic compare(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got result=%0d tick=%0b div_cnt=%0d, expected result=%0d tick=%0b div_cnt=%0d",
               name, $time, act[7:0], act[8], act[24:9], exp[7:0], exp[8], exp[24:9]);
    end
  endtask

  task automatic underflow(input string name);
    checks++;
    errors++;
    $display("FAIL %s t=%0t: output seen with no expected entry", name, $time);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #10;
      if (exp_q4.size() == 0) underflow("div4");
      else compare("div4", {dut4.u_div.div_cnt, dut4.u_div.tick, res4}, exp_q4.pop_front());
      if (exp_q1.size() == 0) underflow("div1");
      else compare("div1", {dut1.u_div.div_cnt, dut1.u_div.tick, res1}, exp_q1.pop_front());
      if (exp_q163.size() == 0) underflow("div163");
      else compare("div163", {dut163.u_div.div_cnt, dut163.u_div.tick, res163}, exp_q163.pop_front());
    end
  end

  // ---------------- driver ----------------
  int n4 = 0, n1 = 0, n163 = 0;
  bit did_mid_reset = 1'b0;

  // Decide resets for edge e, drive them, and push the post-edge expectations.
  task automatic drive_edge(input int e);
    logic [24:0] x;
    bit r4, r1, r163;
    r4   = (e <= 3);
    r1   = (e <= 3) || ($urandom_range(0, 39) == 0);
    r163 = (e <= 3);
    // Mid-count reset at div_cnt==2, result==5.
    if (!did_mid_reset && e > 3 && n4 == 22) begin
      r4 = 1'b1;
      did_mid_reset = 1'b1;
    end
    // Long reset-free stretch first so the 8-bit count passes FF -> 00.
    if (e > 1500 && $urandom_range(0, 49) == 0) r4 = 1'b1;
    rst4   = r4;
    rst1   = r1;
    rst163 = r163;
    model_step(r4,   4,   n4,   x); exp_q4.push_back(x);
    model_step(r1,   1,   n1,   x); exp_q1.push_back(x);
    model_step(r163, 163, n163, x); exp_q163.push_back(x);
  endtask

  initial begin
    drive_edge(1);
    for (int e = 2; e <= NUM_EDGES; e++) begin
      @(posedge clk);
      #5;
      drive_edge(e);
    end
    @(posedge clk);
    #15;
    checks++;
    if (exp_q4.size() != 0 || exp_q1.size() != 0 || exp_q163.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d/%0d entries left, expected 0/0/0",
               exp_q4.size(), exp_q1.size(), exp_q163.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
